// File: rtl/byte_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// byte_serial_adder_ctrl
//
// Multi-byte operand sequencer for an 8-bit add-with-carry datapath. It takes
// a wide operand pair through a valid/ready handshake. It adds the pair one
// byte per clock, starting at the LSB, and holds the inter-byte carry in a
// register. The wide sum and carry_out are then offered downstream through a
// second valid/ready handshake.
//
// Optional feature macro: BYTE_SERIAL_SUB_EN
//   When it is defined, a 1-bit input "sub" is sampled with the operands.
//   With sub=1 the block computes A - B mod 2^W using ~B + 1.
//   In that mode carry_out=1 means no borrow (A >= B).
//
// Parameters
//   NBYTES     operand width in bytes (2..8); W = 8*NBYTES
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream operand pair valid
//   in_ready   block can accept an operand pair (IDLE)
//   op_a/op_b  operands, sampled on the in_valid && in_ready edge
//   sub        (BYTE_SERIAL_SUB_EN only) subtract select, sampled with operands
//   out_valid  result/carry_out valid (DONE)
//   out_ready  downstream accepts the result
//   result     sum modulo 2^W
//   carry_out  carry out of the most-significant byte
// ---------------------------------------------------------------------------
module byte_serial_adder_ctrl #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
`ifdef BYTE_SERIAL_SUB_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry_out
);

    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    // Bit offset of the byte being processed.
    logic [IDXW+2:0] bit_base;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [8:0]      sum;
    logic            carry_init;

`ifdef BYTE_SERIAL_SUB_EN
    logic sub_q, sub_d;
`endif

    assign bit_base = {idx_q, 3'b000};
    assign a_byte   = a_q[bit_base +: 8];

`ifdef BYTE_SERIAL_SUB_EN
    // In subtract mode, ~B plus an initial carry of 1 forms the two's complement of B.
    assign b_byte     = sub_q ? ~b_q[bit_base +: 8] : b_q[bit_base +: 8];
    assign carry_init = sub;
`else
    assign b_byte     = b_q[bit_base +: 8];
    assign carry_init = 1'b0;
`endif

    // The 8-bit add-with-carry slice. carry_q is the only link between bytes.
    assign sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef BYTE_SERIAL_SUB_EN
        sub_d    = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    carry_d = carry_init;
`ifdef BYTE_SERIAL_SUB_EN
                    sub_d   = sub;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                // Bytes not yet written keep their values from the previous
                // transaction. They matter only once out_valid is high.
                result_d[bit_base +: 8] = sum[7:0];
                carry_d                 = sum[8];
                if (idx_q == LAST_IDX) begin
                    cout_d  = sum[8];
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

`ifdef BYTE_SERIAL_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for byte_serial_adder_ctrl with NBYTES=4.
// It covers reset, ripple, backpressure, back-to-back traffic and mid-RUN
// reset. The subtract vectors are included when BYTE_SERIAL_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_byte_serial_adder_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
`ifdef BYTE_SERIAL_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1ns past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until out_valid rises. Return the number of edges taken, or -1 on timeout.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    // A single transaction with out_ready held high and full checking.
    task automatic txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] er, input logic ec);
        int n;
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        op_a = a; op_b = b; sub_r = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op_a = '1; op_b = '1; sub_r = ~s;
        wait_out(n);
        chk({tag, ".lat"}, 64'(n), 64'(NB));
        chk({tag, ".res"}, 64'(result), 64'(er));
        chk({tag, ".cout"}, 64'(carry_out), 64'(ec));
        step();
        chk({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];

    initial begin
        int n;
        int t_prev;
        logic [W:0] g;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub_r = 1'b0;
        #23;
        chk("rst.in_ready", 64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.cout", 64'(carry_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Basic add and carry ripple.
        txn("add_small", 32'h0000_0012, 32'h0000_0034, 1'b0, 32'h0000_0046, 1'b0);
        txn("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        txn("ripple_alt", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0);
        txn("wrap_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

        // Backpressure in DONE, with input traffic that must be ignored.
        out_ready = 1'b0;
        op_a = 32'h1234_5678; op_b = 32'h1111_1111; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out(n);
        chk("bp.lat", 64'(n), 64'(NB));
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            op_a = 32'hDEAD_0000 + 32'(i); op_b = 32'hBEEF_0000;
            step();
            chk("bp.res", 64'(result), 64'h2345_6789);
            chk("bp.cout", 64'(carry_out), 64'd0);
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp.release_ov", 64'(out_valid), 64'd0);
        chk("bp.release_ir", 64'(in_ready), 64'd1);

        // Back-to-back: in_valid and out_ready held high.
        ta[0] = 32'h0000_0001; tb[0] = 32'h0000_0002;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;
        ta[2] = 32'h89AB_CDEF; tb[2] = 32'h7654_3211;
        ta[3] = 32'h0F0F_0F0F; tb[3] = 32'hF0F0_F0F0;
        ta[4] = 32'hA5A5_5A5A; tb[4] = 32'h5A5A_A5A6;
        out_ready = 1'b1;
        in_valid = 1'b1;
        t_prev = -1;
        for (int k = 0; k < 5; k++) begin
            op_a = ta[k]; op_b = tb[k];
            g = {1'b0, ta[k]} + {1'b0, tb[k]};
            n = 0;
            while (!in_ready && n < 10) begin
                step();
                n++;
            end
            chk("b2b.in_ready", 64'(in_ready), 64'd1);
            step();
            if (t_prev >= 0) chk("b2b.spacing", 64'(cyc - t_prev), 64'(NB + 2));
            t_prev = cyc;
            wait_out(n);
            chk("b2b.lat", 64'(n), 64'(NB));
            chk("b2b.res", 64'(result), 64'(g[W-1:0]));
            chk("b2b.cout", 64'(carry_out), 64'(g[W]));
            step();
            chk("b2b.ov_drop", 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        step();

        // Reset during cycle 2 of RUN.
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst.result", 64'(result), 64'd0);
        chk("mrst.cout", 64'(carry_out), 64'd0);
        chk("mrst.out_valid", 64'(out_valid), 64'd0);
        chk("mrst.in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("mrst.no_ov", 64'(out_valid), 64'd0);
        end
        chk("mrst.idle", 64'(in_ready), 64'd1);
        txn("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);

`ifdef BYTE_SERIAL_SUB_EN
        txn("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
        txn("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1);
        txn("sub_off", 32'h0000_0007, 32'h0000_0005, 1'b0, 32'h0000_000C, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Backstop in case a wait escapes its bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/byte_serial_adder_ctrl.md
Name: byte_serial_adder_ctrl

Overview:
Multi-byte operand sequencer that sits directly upstream of the team's 8-bit carry-select adder slice and consumes its output. It accepts two wide operands through a valid/ready handshake and feeds them one byte per cycle into an 8-bit add-with-carry datapath. Between bytes it holds the inter-byte carry in a register, assembles the wide sum, and presents it downstream through a second valid/ready handshake. This lets the 8-bit adder serve 16/32/64-bit additions at one byte per clock.

Parameters:
NBYTES, 4, operand width in bytes (legal 2..8); operand/result width W = 8*NBYTES

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream operand pair valid
in_ready  output  1  block can accept an operand pair
op_a  input  W  operand A, sampled only on the in_valid&&in_ready edge
op_b  input  W  operand B, sampled only on the in_valid&&in_ready edge
out_valid  output  1  result and carry_out are valid
out_ready  input  1  downstream accepts the result
result  output  W  sum modulo 2^W
carry_out  output  1  carry out of the most-significant byte

Behaviour:
- Reset (async assert, sync release on rst_n high): state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, byte index=0, carry register=0, operand registers=0.
- Reset asserted mid-operation aborts immediately. The in-flight transaction is discarded and no out_valid follows.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: latch op_a/op_b, clear byte index and carry register, go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle the datapath computes {c, s} = A[idx] + B[idx] + carry_reg, where A[idx] is byte idx of A (bits 8*idx+7 : 8*idx).
  - s is written into result byte idx; c is written into carry_reg; idx increments.
  - The add for byte idx = NBYTES-1 also loads carry_out = c and moves to DONE.
  - RUN lasts exactly NBYTES cycles.
- State DONE:
  - out_valid=1, in_ready=0.
  - result and carry_out stay stable until accepted.
  - On out_ready=1: go to IDLE; out_valid drops on the next edge.
- Latency: handshake edge T accepts operands; out_valid rises at edge T+NBYTES. Minimum spacing between accepted transactions is NBYTES+2 cycles.
- out_ready=1 held permanently: out_valid is high for exactly one cycle.
- out_ready=0 in DONE: stall indefinitely with no state change. Operand inputs are ignored.
- in_valid in RUN/DONE has no effect; upstream must hold its pair until in_ready=1.
- result bytes not yet written during RUN keep stale values; they are only meaningful when out_valid=1.
- Arithmetic is unsigned; the wrap at 2^W is reported only via carry_out.
- The carry chain is purely LSB→MSB; the register carry is the only inter-byte path.

Optional Feature:
Macro: BYTE_SERIAL_SUB_EN
- Defined:
  - An extra input port sub (1 bit) is sampled together with the operands.
  - When sub=1, B bytes are bit-inverted before the add and carry_reg is initialised to 1, so result = A - B mod 2^W.
  - carry_out = 1 means no borrow (A >= B).
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; addition only; carry_reg is initialised to 0.

Test Plan:
1. Reset then basic add: NBYTES=4, A=0x0000_0012, B=0x0000_0034 -> out_valid at T+4, result=0x0000_0046, carry_out=0.
2. Full carry ripple: A=0xFFFF_FFFF, B=0x0000_0001 -> result=0x0000_0000, carry_out=1. Also A=0x00FF_00FF, B=0x0001_0001 -> result=0x0100_0100, carry_out=0.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid, while toggling in_valid with new operands -> result stable, in_ready=0 throughout. Release out_ready -> one-cycle acceptance, then IDLE with in_ready=1.
4. Back-to-back: in_valid and out_ready tied high, random pairs -> each result matches the 32-bit golden model, and transactions complete every 6 cycles.
5. Reset mid-RUN: drop rst_n at cycle 2 of RUN -> all outputs immediately zero, in_ready=1 after release, and no spurious out_valid.
6. BYTE_SERIAL_SUB_EN defined, sub=1: A=0x0000_0005, B=0x0000_0007 -> result=0xFFFF_FFFE, carry_out=0. Then A=7, B=5 -> result=2, carry_out=1.
